half_subtractor: RTL and testbench
==================================

Name: half_subtractor

Overview:
- Bit-parallel half-subtractor bank: computes a − b per bit position with no borrow-in.
- Provides combinational outputs (same-cycle) and a registered, valid-qualified copy for pipelined consumers.
- Leaf arithmetic primitive, used by full-subtractor and comparator datapaths.
- WIDTH=1 gives the classic single-bit half subtractor.

Parameters:
- WIDTH, 1, number of independent bit lanes (≥1).

Ports:
- clk  input  1  rising-edge clock for registered outputs
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies a/b for capture into output registers
- a  input  WIDTH  minuend bits
- b  input  WIDTH  subtrahend bits
- diff  output  WIDTH  combinational difference, a XOR b per bit
- brw  output  WIDTH  combinational borrow, (NOT a) AND b per bit
- diff_q  output  WIDTH  registered diff
- brw_q  output  WIDTH  registered brw
- out_valid  output  1  registered in_valid
- any_brw_q  output  1  registered OR-reduction of brw (set when any lane borrows)

Behaviour:
- Lanes are fully independent; no borrow propagates between bits.
- Combinational path (diff, brw):
  - Zero latency; depends only on a and b.
  - Unaffected by clk, rst_n and in_valid.
  - Valid truth table per bit (a,b → diff,brw): 00→0,0; 01→1,1; 10→1,0; 11→0,0.
- Registered path:
  - rst_n low, asynchronously: diff_q=0, brw_q=0, any_brw_q=0, out_valid=0, held while rst_n is low.
  - Rising clk with in_valid=1: diff_q, brw_q and any_brw_q load the current combinational values; out_valid←1.
  - Rising clk with in_valid=0: diff_q, brw_q and any_brw_q hold their previous values; out_valid←0.
  - Latency is 1 cycle from in_valid/a/b to out_valid/diff_q/brw_q.
- Reset deassertion is sampled at the next clk edge; the first capture needs in_valid=1 at that edge.
- Reset asserted mid-stream: registered outputs clear immediately; the combinational outputs keep tracking a and b.
- X/Z on a or b propagates to the outputs; no special handling.
- No state machine; no handshake backpressure (always ready).

Decomposition:
- Shared package: none required. Optionally a localparam for the WIDTH default.
- One sub-module, half_sub_cell: single-bit diff/brw combinational cell, instantiated WIDTH times via generate.
- Top level holds the output registers and the borrow reduction.

Test Plan:
- WIDTH=1, drive {a,b}=0,1,2,3 at 10 ns steps → (diff,brw) = (0,0),(1,1),(1,0),(0,0), each settled within the same step, no clock needed.
- Same sweep with in_valid=1 on each clk → one cycle later diff_q/brw_q match the prior step's values; out_valid=1.
- Reset: load a=0,b=1 (brw_q=1), then assert rst_n=0 between edges → diff_q, brw_q, any_brw_q and out_valid go to 0 immediately; diff=1 and brw=1 are unchanged.
- Hold: capture a=1,b=0, then change to a=1,b=1 with in_valid=0 → diff_q=1 and brw_q=0 are retained; out_valid=0; combinational diff=0.
- WIDTH=4: a=4'b1010, b=4'b0110 → diff=4'b1100, brw=4'b0100, any_brw_q=1 after capture. Repeat with a=4'b1111,b=4'b0000 → brw=0, any_brw_q=0.
- Exhaustive random sweep, WIDTH=4, 256 combinations → diff==a^b and brw==~a&b every vector.

Source files
------------

// File: rtl/half_subtractor_pkg.sv
// Shared definitions for the half-subtractor bank.
//   HS_WIDTH_DEFAULT : default lane count (1 = classic single-bit half subtractor)
package half_subtractor_pkg;

  localparam int unsigned HS_WIDTH_DEFAULT = 1;

endpackage : half_subtractor_pkg

// File: rtl/half_sub_cell.sv
// Single-bit half subtractor cell: computes a - b with no borrow-in.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   diff : a XOR b
//   brw  : borrow out, (NOT a) AND b
module half_sub_cell (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic brw
);

  assign diff = a ^ b;
  assign brw  = ~a & b;

endmodule : half_sub_cell

// File: rtl/half_subtractor.sv
// Bit-parallel half-subtractor bank with combinational outputs and a
// registered, valid-qualified copy for pipelined consumers.
// Ports:
//   clk       : rising-edge clock for the registered outputs
//   rst_n     : asynchronous active-low reset (registered outputs only)
//   in_valid  : qualifies a/b for capture into the output registers
//   a, b      : minuend / subtrahend, WIDTH independent lanes
//   diff, brw : combinational difference and borrow per lane
//   diff_q    : registered diff (holds when in_valid is low)
//   brw_q     : registered brw  (holds when in_valid is low)
//   out_valid : registered in_valid
//   any_brw_q : registered OR of all brw lanes
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] brw,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] brw_q,
  output logic             out_valid,
  output logic             any_brw_q
);

  // Lanes are fully independent: no borrow chains between bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_sub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .diff (diff[i]),
      .brw  (brw[i])
    );
  end

  // Data registers hold when in_valid is low; out_valid simply follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      brw_q     <= '0;
      any_brw_q <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff_q    <= diff;
        brw_q     <= brw;
        any_brw_q <= |brw;
      end
    end
  end

endmodule : half_subtractor

// File: tb/tb_half_subtractor.sv
module tb_half_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;

  // WIDTH=1 instance
  logic       v1;
  logic [0:0] a1, b1, d1, br1, dq1, bq1;
  logic       ov1, ab1;

  // WIDTH=4 instance
  logic       v4;
  logic [3:0] a4, b4, d4, br4, dq4, bq4;
  logic       ov4, ab4;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  half_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .diff(d1), .brw(br1), .diff_q(dq1), .brw_q(bq1),
    .out_valid(ov1), .any_brw_q(ab1)
  );

  half_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4),
    .diff(d4), .brw(br4), .diff_q(dq4), .brw_q(bq4),
    .out_valid(ov4), .any_brw_q(ab4)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Expected (diff,brw) for {a,b} = 0..3
  logic [1:0] exp_tab [4] = '{2'b00, 2'b11, 2'b10, 2'b00};

  initial begin
    rst_n = 1'b0; v1 = 1'b0; v4 = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    #2;
    // Reset state
    chk("rst_dq1", 4'(dq1), 4'd0);
    chk("rst_bq1", 4'(bq1), 4'd0);
    chk("rst_ov1", 4'(ov1), 4'd0);
    chk("rst_ab1", 4'(ab1), 4'd0);
    chk("rst_dq4", dq4, 4'd0);
    chk("rst_ov4", 4'(ov4), 4'd0);

    // Combinational sweep, WIDTH=1, while held in reset
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      #10;
      chk($sformatf("comb_diff_%0d", i), 4'(d1), 4'(exp_tab[i][1]));
      chk($sformatf("comb_brw_%0d", i),  4'(br1), 4'(exp_tab[i][0]));
    end
    chk("rst_held_ov1", 4'(ov1), 4'd0);

    // Release reset between edges
    @(negedge clk);
    rst_n = 1'b1;

    // Registered sweep
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {a1, b1} = 2'(i);
      v1 = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("reg_dq_%0d", i), 4'(dq1), 4'(exp_tab[i][1]));
      chk($sformatf("reg_bq_%0d", i), 4'(bq1), 4'(exp_tab[i][0]));
      chk($sformatf("reg_ov_%0d", i), 4'(ov1), 4'd1);
      chk($sformatf("reg_ab_%0d", i), 4'(ab1), 4'(exp_tab[i][0]));
    end

    // Hold: capture a=1,b=0 then present a=1,b=1 without in_valid
    @(negedge clk); a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    chk("hold_cap_dq", 4'(dq1), 4'd1);
    @(negedge clk); a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
    @(posedge clk); #1;
    chk("hold_dq", 4'(dq1), 4'd1);
    chk("hold_bq", 4'(bq1), 4'd0);
    chk("hold_ov", 4'(ov1), 4'd0);
    chk("hold_diff", 4'(d1), 4'd0);

    // Mid-stream asynchronous reset
    @(negedge clk); a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_bq", 4'(bq1), 4'd1);
    chk("pre_rst_ab", 4'(ab1), 4'd1);
    #2; rst_n = 1'b0; #1;
    chk("arst_dq", 4'(dq1), 4'd0);
    chk("arst_bq", 4'(bq1), 4'd0);
    chk("arst_ab", 4'(ab1), 4'd0);
    chk("arst_ov", 4'(ov1), 4'd0);
    chk("arst_diff", 4'(d1), 4'd1);
    chk("arst_brw", 4'(br1), 4'd1);
    @(negedge clk); rst_n = 1'b1; v1 = 1'b0;

    // WIDTH=4 directed
    @(negedge clk); a4 = 4'b1010; b4 = 4'b0110; v4 = 1'b1;
    #1;
    chk("w4_diff_a", d4, 4'b1100);
    chk("w4_brw_a", br4, 4'b0100);
    @(posedge clk); #1;
    chk("w4_dq_a", dq4, 4'b1100);
    chk("w4_bq_a", bq4, 4'b0100);
    chk("w4_ab_a", 4'(ab4), 4'd1);
    chk("w4_ov_a", 4'(ov4), 4'd1);
    @(negedge clk); a4 = 4'b1111; b4 = 4'b0000;
    #1;
    chk("w4_diff_b", d4, 4'b1111);
    chk("w4_brw_b", br4, 4'b0000);
    @(posedge clk); #1;
    chk("w4_dq_b", dq4, 4'b1111);
    chk("w4_ab_b", 4'(ab4), 4'd0);
    @(negedge clk); v4 = 1'b0;

    // Exhaustive WIDTH=4 combinational sweep
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ab;
      ab = 8'(i);
      a4 = ab[7:4];
      b4 = ab[3:0];
      #1;
      chk($sformatf("sweep_diff_%0d", i), d4, ab[7:4] ^ ab[3:0]);
      chk($sformatf("sweep_brw_%0d", i), br4, ~ab[7:4] & ab[3:0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_half_subtractor
